// File: rtl/common_pkg.sv
// Shared types for the tiny CPU control path: decoder op codes and sequencer states.
package common_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_FLAGS = 2'd1,
      OP_JUMP  = 2'd2
   } ctrl_op_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      COPY    = 2'd2,
      RESOLVE = 2'd3
   } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for branch statistics; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk_in,
   input  logic             reset_n_in,
   input  logic             inc_in,
   output logic [CNT_W-1:0] count_out
);

   always_ff @(posedge clk_in) begin
      if (!reset_n_in) begin
         count_out <= '0;
      end else if (inc_in && (count_out != {CNT_W{1'b1}})) begin
         count_out <= count_out + CNT_W'(1);
      end
   end

endmodule

// File: rtl/branch_sequencer.sv
// Status-flag sequencer: commits ALU flags, evaluates conditional jumps through the status
// register and issues exactly one PC action (load or increment) per accepted op.
module branch_sequencer
   import common_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk_in,
   input  logic              reset_n_in,
   input  logic              op_valid_in,
   output logic              op_ready_out,
   input  logic [1:0]        op_type_in,
   input  logic [3:0]        op_mask_in,
   input  logic              op_invert_in,
   input  logic [ADDR_W-1:0] op_target_in,
   input  logic [3:0]        alu_flags_in,
   output logic [3:0]        status_data_out,
   output logic              status_write_en_out,
   output logic [3:0]        status_inst_out,
   output logic              status_copy_en_out,
   output logic              status_invert_out,
   input  logic              cond_in,
   output logic              pc_load_out,
   output logic [ADDR_W-1:0] pc_target_out,
   output logic              pc_inc_out,
   output logic [CNT_W-1:0]  taken_cnt_out,
   output logic [CNT_W-1:0]  not_taken_cnt_out
);

   seq_state_t state;
   logic       write_inc_q;
   logic       resolve_q;

   // Strobes default low every cycle and are raised only on the transition into their state,
   // so each one is a registered, single-cycle decode of the state it belongs to.
   always_ff @(posedge clk_in) begin
      if (!reset_n_in) begin
         state               <= IDLE;
         op_ready_out        <= 1'b0;
         status_data_out     <= '0;
         status_write_en_out <= 1'b0;
         status_inst_out     <= '0;
         status_copy_en_out  <= 1'b0;
         status_invert_out   <= 1'b0;
         pc_target_out       <= '0;
         write_inc_q         <= 1'b0;
         resolve_q           <= 1'b0;
      end else begin
         status_write_en_out <= 1'b0;
         status_copy_en_out  <= 1'b0;
         write_inc_q         <= 1'b0;
         resolve_q           <= 1'b0;
         case (state)
            IDLE: begin
               if (op_valid_in && op_ready_out) begin
                  op_ready_out <= 1'b0;
                  case (ctrl_op_t'(op_type_in))
                     OP_FLAGS: begin
                        state               <= WRITE;
                        status_write_en_out <= 1'b1;
                        status_data_out     <= alu_flags_in;
                        write_inc_q         <= 1'b1;
                     end
                     OP_JUMP: begin
                        state              <= COPY;
                        status_copy_en_out <= 1'b1;
                        status_inst_out    <= op_mask_in;
                        status_invert_out  <= op_invert_in;
                        pc_target_out      <= op_target_in;
                     end
                     default: begin
                        state       <= WRITE;
                        write_inc_q <= 1'b1;
                     end
                  endcase
               end else begin
                  op_ready_out <= 1'b1;
               end
            end
            WRITE: begin
               state        <= IDLE;
               op_ready_out <= 1'b1;
            end
            COPY: begin
               state     <= RESOLVE;
               resolve_q <= 1'b1;
            end
            RESOLVE: begin
               state        <= IDLE;
               op_ready_out <= 1'b1;
            end
            default: begin
               state        <= IDLE;
               op_ready_out <= 1'b0;
            end
         endcase
      end
   end

   // cond_in only becomes valid one cycle after the copy strobe, so RESOLVE gates it directly.
   assign pc_load_out = resolve_q & cond_in;
   assign pc_inc_out  = write_inc_q | (resolve_q & ~cond_in);

   sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
      .clk_in     (clk_in),
      .reset_n_in (reset_n_in),
      .inc_in     (resolve_q & cond_in),
      .count_out  (taken_cnt_out)
   );

   sat_counter #(.CNT_W(CNT_W)) u_not_taken_cnt (
      .clk_in     (clk_in),
      .reset_n_in (reset_n_in),
      .inc_in     (resolve_q & ~cond_in),
      .count_out  (not_taken_cnt_out)
   );

endmodule
